// File: rtl/radix2_booth_multiplier.sv
// Sequential signed multiplier, one radix-2 Booth step per clock.
// Start loads operands; product and ready appear WIDTH cycles later.
module radix2_booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               start,
  output logic [2*WIDTH-1:0] out,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_q1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_out;
  logic               r_ready;

  logic [WIDTH:0]     w_sum;
  logic               w_last;

  // A is one bit wider than the operands so A-M never overflows.
  always_comb begin
    w_sum = r_a;
    unique case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_ready <= 1'b0;
    end else if (start) begin
      r_state <= BUSY;
      r_a     <= '0;
      r_m     <= {ina[WIDTH-1], ina};
      r_q     <= inb;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        BUSY: begin
          r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // Low 2*WIDTH bits of the shifted {A,Q}.
            r_out   <= {w_sum[WIDTH-1:0], r_q[WIDTH-1:0]} >> 1
                       | {w_sum[WIDTH], {(2*WIDTH-1){1'b0}}};
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign ready = r_ready;

endmodule

// File: tb/tb_radix2_booth_multiplier.sv
// Directed and random checks for radix2_booth_multiplier (WIDTH=8).
// Inputs are driven and outputs sampled on the falling edge.
module tb_radix2_booth_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [W-1:0]   ina;
  logic [W-1:0]   inb;
  logic           start;
  logic [2*W-1:0] out;
  logic           ready;

  int n_cmp;
  int n_err;

  radix2_booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .ina   (ina),
    .inb   (inb),
    .start (start),
    .out   (out),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ina   = a;
    inb   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int lat;
    pulse(a, b);
    wait_ready(lat);
    chk({tag, "_lat"}, lat, 8);
    chk(tag, {16'h0, out}, {16'h0, exp});
  endtask

  initial begin
    int lat;
    int pa;
    int pb;
    logic [2*W-1:0] ref_p;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    ina   = '0;
    inb   = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {16'h0, out}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {15'h0, ready, out}, 32'h0);
    end

    run("p3x5", 8'd3, 8'd5, 16'h000F);
    run("p0xm77", 8'd0, 8'hB3, 16'h0000);
    run("m7x6", 8'hF9, 8'd6, 16'hFFD6);
    run("p127xm128", 8'h7F, 8'h80, 16'hC080);
    run("m128xm128", 8'h80, 8'h80, 16'h4000);
    run("m1xm1", 8'hFF, 8'hFF, 16'h0001);

    // Restart mid-operation with garbage operands in between.
    pulse(8'd3, 8'd5);
    ina = 8'hAA;
    inb = 8'h55;
    for (int i = 0; i < 3; i++) begin
      chk("busy_ready", {31'h0, ready}, 32'h0);
      chk("busy_out", {16'h0, out}, 32'h0001);
      @(negedge clk);
    end
    pulse(8'hFE, 8'd9);
    ina = 8'h5A;
    inb = 8'hC3;
    wait_ready(lat);
    chk("restart_lat", lat, 8);
    chk("restart_out", {16'h0, out}, 32'h0000FFEE);

    // Reset in the middle of an operation.
    pulse(8'd7, 8'd7);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out", {16'h0, out}, 32'h0);
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_ready", {31'h0, ready}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      ina = W'($urandom_range(0, 255));
      inb = W'($urandom_range(0, 255));
      pa  = $signed(ina);
      pb  = $signed(inb);
      ref_p = 16'(pa * pb);
      pulse(ina, inb);
      repeat (18) @(negedge clk);
      chk("rand_ready", {31'h0, ready}, 32'h1);
      chk("rand_out", {16'h0, out}, {16'h0, ref_p});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/radix2_booth_multiplier.md
Name: radix2_booth_multiplier

Overview:
Sequential signed multiplier using radix-2 Booth recoding. It computes one Booth step per clock and produces a full-width two's-complement product WIDTH cycles after a start pulse. It is a multi-cycle arithmetic unit for datapaths that can trade latency for area, and is interchangeable with the team's other start/ready sequential multipliers.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
ina  input  WIDTH  multiplicand, signed two's complement.
inb  input  WIDTH  multiplier, signed two's complement.
start  input  1  start request, sampled on the rising edge of clk.
out  output  2*WIDTH  signed product ina*inb; registered.
ready  output  1  high when out holds a completed product.

Behaviour:
- Reset (asynchronous, active-high): out=0, ready=0, FSM to IDLE, internal accumulator, multiplier shift register, Booth bit and step counter cleared.
- FSM states: IDLE, BUSY.
- start=1 at an edge, in any state: latch M=ina sign-extended to WIDTH+1 bits, Q=inb, Q(-1)=0, accumulator A=0 (WIDTH+1 bits), counter=0; go to BUSY; ready<=0. out keeps its previous value.
- BUSY, each edge with start=0: examine {Q[0],Q(-1)}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no change. Then arithmetic-shift right {A,Q,Q(-1)} by one (A MSB replicated). Counter increments.
- After the WIDTH-th step: out <= low 2*WIDTH bits of {A,Q} (the product); ready<=1; return to IDLE.
- Latency: with start sampled at edge N, ready rises and out is valid after edge N+WIDTH (WIDTH busy steps). Both hold until the next start or reset.
- Operands are sampled only at the start edge; changes to ina/inb during BUSY have no effect.
- start while BUSY aborts the current operation and restarts with the new operands; no result for the aborted operation appears.
- start held high for several cycles reloads on every such edge; computation begins at the first edge with start=0.
- A is WIDTH+1 bits so that subtracting M = -2^(WIDTH-1) does not overflow. Result is exact for all operand pairs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
- out is two's complement. For WIDTH=8, interpreting out as unsigned gives the 16-bit two's-complement pattern.
- Reset asserted mid-operation abandons it immediately. After reset deassertion the block waits in IDLE with ready=0.

Test Plan:
- Reset then idle: rst pulse -> out=0, ready=0, and both remain 0 with start=0 for 20 cycles.
- Basic positive product (WIDTH=8): ina=3, inb=5, 1-cycle start -> ready=1 exactly 8 cycles later, out=15 (0x000F). Also check ina=0, inb=-77 -> out=0.
- Mixed signs: ina=-7, inb=6 -> out=-42 (0xFFD6). Also ina=127, inb=-128 -> out=-16256 (0xC080).
- Extreme negatives: ina=-128, inb=-128 -> out=16384 (0x4000). Also ina=-1, inb=-1 -> out=1.
- Restart and operand stability: start with 3*5, change ina/inb to garbage during BUSY, then at cycle 4 pulse start with -2*9 -> no ready for 3*5; ready 8 cycles after the second start with out=-18 (0xFFEE). During BUSY, out keeps the previous completed product.
- Reset mid-operation and back-to-back: assert rst at cycle 3 of BUSY -> out=0, ready=0 immediately. Then run 20 random pairs with start every 20 cycles -> each out equals the signed reference product.
